// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front-end: FSM state encoding and default
// reset PC / PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int unsigned FETCH_PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that returned while the queue
// was full; flush has priority over load, load over drain.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  drain,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [ADDR_WIDTH-1:0] pc_r;

    // entry register: flush > load > drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            pc_r    <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            pc_r    <= load_pc;
        end else if (drain) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign pc    = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests and queue push with redirect flush.
// Define FETCH_SKID_EN to park full-queue responses in a skid register instead of replaying.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(FETCH_RESET_PC),
    parameter int unsigned           PC_STEP     = FETCH_PC_STEP
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   queue_full,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   enqueue,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic [31:0]            fetch_count
);

    state_t                 state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0]  pc_r, pc_nxt_s, inflight_pc_r, restore_pc_s;
    logic                   inflight_valid_r;
    logic [31:0]            count_r;
    logic                   req_s, enq_s, restore_s, skid_hold_s, skid_valid_s;
    logic [INSTR_WIDTH-1:0] instr_s;

    assign req_s = (state_r == S_RUN) && !queue_full && !redirect && !skid_valid_s;

`ifdef FETCH_SKID_EN
    logic                   skid_load_s, skid_drain_s;
    logic [INSTR_WIDTH-1:0] skid_data_s;
    logic [ADDR_WIDTH-1:0]  skid_pc_s;

    fetch_skid_buffer #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .load      (skid_load_s),
        .drain     (skid_drain_s),
        .flush     (redirect),
        .load_data (imem_rdata),
        .load_pc   (inflight_pc_r),
        .valid     (skid_valid_s),
        .data      (skid_data_s),
        .pc        (skid_pc_s)
    );

    // response steering: a parked entry drains before any new response; full responses park
    always_comb begin
        enq_s        = 1'b0;
        instr_s      = '0;
        skid_load_s  = 1'b0;
        skid_drain_s = 1'b0;
        restore_s    = 1'b0;
        restore_pc_s = skid_pc_s + ADDR_WIDTH'(PC_STEP);
        if (redirect) begin
            enq_s = 1'b0;
        end else if (skid_valid_s) begin
            if (!queue_full) begin
                enq_s        = 1'b1;
                instr_s      = skid_data_s;
                skid_drain_s = 1'b1;
                // fetch resumes right after the drained entry
                restore_s    = 1'b1;
            end else begin
                skid_drain_s = 1'b0;
            end
        end else if (inflight_valid_r) begin
            if (!queue_full) begin
                enq_s   = 1'b1;
                instr_s = imem_rdata;
            end else begin
                skid_load_s = 1'b1;
            end
        end else begin
            enq_s = 1'b0;
        end
        skid_hold_s = skid_valid_s && !skid_drain_s;
    end
`else
    assign skid_valid_s = 1'b0;

    // response steering: a response hitting a full queue is dropped and its address replayed
    always_comb begin
        enq_s        = 1'b0;
        instr_s      = '0;
        restore_s    = 1'b0;
        restore_pc_s = inflight_pc_r;
        skid_hold_s  = 1'b0;
        if (!redirect && inflight_valid_r) begin
            if (!queue_full) begin
                enq_s   = 1'b1;
                instr_s = imem_rdata;
            end else begin
                restore_s = 1'b1;
            end
        end else begin
            enq_s = 1'b0;
        end
    end
`endif

    // next state and next PC; redirect overrides everything
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        if (redirect) begin
            state_nxt_s = S_RUN;
            pc_nxt_s    = redirect_pc;
        end else begin
            case (state_r)
                S_BOOT: state_nxt_s = S_RUN;
                S_RUN: begin
                    if (queue_full || skid_hold_s) begin
                        state_nxt_s = S_HOLD;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
                S_HOLD: begin
                    if (!queue_full && !skid_hold_s) begin
                        state_nxt_s = S_RUN;
                    end else begin
                        state_nxt_s = S_HOLD;
                    end
                end
                default: state_nxt_s = S_BOOT;
            endcase
            if (req_s) begin
                pc_nxt_s = pc_r + ADDR_WIDTH'(PC_STEP);
            end else if (restore_s) begin
                pc_nxt_s = restore_pc_s;
            end else begin
                pc_nxt_s = pc_r;
            end
        end
    end

    // architectural state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= S_BOOT;
            pc_r             <= RESET_PC;
            inflight_valid_r <= 1'b0;
            inflight_pc_r    <= RESET_PC;
            count_r          <= 32'd0;
        end else begin
            state_r          <= state_nxt_s;
            pc_r             <= pc_nxt_s;
            inflight_valid_r <= req_s;
            if (req_s) begin
                inflight_pc_r <= pc_r;
            end else begin
                inflight_pc_r <= inflight_pc_r;
            end
            if (enq_s) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = pc_r;
    assign enqueue     = enq_s;
    assign fetch_instr = instr_s;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random full/redirect
// traffic against an in-order expected-address scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        queue_full = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req, enqueue;
    logic [31:0] imem_addr, fetch_instr, fetch_count;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] exp_cnt = 32'd0;
    int          idle = 0;
    logic        s_req, s_enq;
    logic [31:0] s_addr, s_instr, s_cnt;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .queue_full  (queue_full),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .enqueue     (enqueue),
        .fetch_instr (fetch_instr),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // word-indexed instruction memory, one-cycle read latency
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr >> 2;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // one clock: drive inputs, sample at negedge, update scoreboard
    task automatic step(input logic f, input logic r, input logic [31:0] rp);
        queue_full  = f;
        redirect    = r;
        redirect_pc = rp;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_enq   = enqueue;
        s_instr = fetch_instr;
        s_cnt   = fetch_count;
        if (!reset) begin
            check_val("rst_req", imem_req, 32'd0);
            check_val("rst_enq", enqueue, 32'd0);
            check_val("rst_instr", fetch_instr, 32'd0);
            check_val("rst_count", fetch_count, 32'd0);
            check_val("rst_addr", imem_addr, 32'd0);
            exp_pc  = 32'd0;
            exp_cnt = 32'd0;
            idle    = 0;
        end else begin
            check_val("count", fetch_count, exp_cnt);
            if (f || r) check_val("enq_blocked", enqueue, 32'd0);
            if (r) check_val("req_on_redirect", imem_req, 32'd0);
            if (enqueue && !f && !r) begin
                check_val("instr_seq", fetch_instr, exp_pc >> 2);
                exp_pc  = exp_pc + 32'd4;
                exp_cnt = exp_cnt + 32'd1;
            end else if (!enqueue) begin
                check_val("instr_idle_zero", fetch_instr, 32'd0);
            end
            if (r) begin
                exp_pc = rp;
                idle   = 0;
            end else if (f || enqueue) begin
                idle = 0;
            end else begin
                idle++;
                check_val("stall_bound", idle > 4, 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        logic found;

        // 1: boot timing and back-to-back fetch
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        check_val("t1_boot_noreq", s_req, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_val("t1_req", s_req, 32'd1);
        check_val("t1_addr", s_addr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0);
            check_val("t1_enq", s_enq, 32'd1);
            check_val("t1_instr", s_instr, i);
        end
        step(1'b0, 1'b0, 32'd0);
        check_val("t1_count", s_cnt, 32'd4);

        // 2: full in the response cycle of 0x8
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check_val("t2_full_noenq", s_enq, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
`ifdef FETCH_SKID_EN
        check_val("t2_skid_enq", s_enq, 32'd1);
        check_val("t2_skid_instr", s_instr, 32'd2);
`endif
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0);
        check_val("t2_progress", fetch_count >= 32'd4, 32'd1);

        // 3: redirect while 0x10 is in flight
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'd0);
            if (s_req && s_addr == 32'h10) found = 1'b1;
        end
        check_val("t3_saw_0x10", found, 32'd1);
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'd0);
        check_val("t3_req", s_req, 32'd1);
        check_val("t3_addr", s_addr, 32'h100);
        check_val("t3_noenq", s_enq, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_val("t3_instr", s_instr, 32'h40);

        // 4: redirect together with full and a parked/dropped response
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'd0);
        check_val("t4_req", s_req, 32'd1);
        check_val("t4_addr", s_addr, 32'h100);
        check_val("t4_noenq", s_enq, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_val("t4_instr", s_instr, 32'h40);

        // 5: PC wraps past the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        check_val("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        check_val("t5_addr_wrap", s_addr, 32'd0);
        check_val("t5_instr_top", s_instr, 32'h3FFF_FFFF);
        step(1'b0, 1'b0, 32'd0);
        check_val("t5_instr_wrap", s_instr, 32'd0);

        // 6: asynchronous reset in the middle of an enqueue
        queue_full = 1'b0;
        redirect   = 1'b0;
        @(negedge clk);
        check_val("t6_pre_enq", enqueue, 32'd1);
        reset = 1'b0;
        #1;
        check_val("t6_enq", enqueue, 32'd0);
        check_val("t6_req", imem_req, 32'd0);
        check_val("t6_instr", fetch_instr, 32'd0);
        check_val("t6_count", fetch_count, 32'd0);
        check_val("t6_addr", imem_addr, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_val("t6_restart_addr", s_addr, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_val("t6_restart_instr", s_instr, 32'd0);

        // random backpressure and redirects
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
                 $urandom & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
